// File: rtl/fp_conv_pkg.sv
// fp_conv_pkg: shared definitions for the FloPoCo -> IEEE converter pipe.
//   exn_e      : FloPoCo 2-bit exception field encodings
//   FLAG_*     : bit positions inside the 4-bit sticky flag vector {nan, inf, ovf, unf}
//   quiet_nan(): IEEE quiet-NaN pattern (sign 0, exp all ones, frac MSB set)
//                for a given exponent/fraction width, right-aligned in QNAN_MAX_W bits
package fp_conv_pkg;

  typedef enum logic [1:0] {
    EXN_ZERO = 2'b00,
    EXN_NORM = 2'b01,
    EXN_INF  = 2'b10,
    EXN_NAN  = 2'b11
  } exn_e;

  localparam logic [1:0] FLAG_UNF = 2'd0;
  localparam logic [1:0] FLAG_OVF = 2'd1;
  localparam logic [1:0] FLAG_INF = 2'd2;
  localparam logic [1:0] FLAG_NAN = 2'd3;

  localparam int unsigned QNAN_MAX_W = 128;

  function automatic logic [QNAN_MAX_W-1:0] quiet_nan(input int unsigned we, input int unsigned wf);
    logic [QNAN_MAX_W-1:0] r;
    r = ((QNAN_MAX_W'(1) << we) - QNAN_MAX_W'(1)) << wf;
    r = r | (QNAN_MAX_W'(1) << (wf - 1));
    return r;
  endfunction

endpackage

// File: rtl/fp_conv_pipe_if.sv
// fp_conv_pipe_if: stream/handshake bundle of the converter pipe.
//   push_in/flopoco_float/tag_in/ready_out : upstream side
//   push_out/ieee_float/tag_out/stall_in   : downstream side
//   clr_flags/flags_out                    : sticky exception flags {nan, inf, ovf, unf}
//   master modport: the producer/consumer environment; slave modport: the pipe.
interface fp_conv_pipe_if #(
  parameter int unsigned WE    = 11,
  parameter int unsigned WF    = 52,
  parameter int unsigned TAG_W = 8
);
  logic                 push_in;
  logic [WE+WF+2:0]     flopoco_float;
  logic [TAG_W-1:0]     tag_in;
  logic                 ready_out;
  logic                 push_out;
  logic                 stall_in;
  logic [WE+WF:0]       ieee_float;
  logic [TAG_W-1:0]     tag_out;
  logic                 clr_flags;
  logic [3:0]           flags_out;

  modport master (
    output push_in, flopoco_float, tag_in, stall_in, clr_flags,
    input  ready_out, push_out, ieee_float, tag_out, flags_out
  );

  modport slave (
    input  push_in, flopoco_float, tag_in, stall_in, clr_flags,
    output ready_out, push_out, ieee_float, tag_out, flags_out
  );
endinterface

// File: rtl/fp_conv_core.sv
// fp_conv_core: combinational FloPoCo -> IEEE conversion plus flag classification.
//   flopoco_float : {exn[1:0], sign, exp[WE-1:0], frac[WF-1:0]}
//   ieee_float    : {sign, exp[WE-1:0], frac[WF-1:0]}
//   flags         : class of this word {nan, inf, ovf, unf}
// Optional feature macro FP_CONV_SUBNORMAL_EN: exp==0 normals become rounded
// IEEE subnormals instead of flushing to signed zero.
module fp_conv_core
  import fp_conv_pkg::*;
#(
  parameter int unsigned WE = 11,
  parameter int unsigned WF = 52
) (
  input  logic [WE+WF+2:0] flopoco_float,
  output logic [WE+WF:0]   ieee_float,
  output logic [3:0]       flags
);

  localparam logic [QNAN_MAX_W-1:0] QNAN_FULL = quiet_nan(WE, WF);
  localparam logic [WE+WF:0]        QNAN      = QNAN_FULL[WE+WF:0];

  exn_e          exn;
  logic          sign;
  logic [WE-1:0] exp;
  logic [WF-1:0] frac;

  assign exn  = exn_e'(flopoco_float[WE+WF+2 -: 2]);
  assign sign = flopoco_float[WE+WF];
  assign exp  = flopoco_float[WE+WF-1 -: WE];
  assign frac = flopoco_float[WF-1:0];

`ifdef FP_CONV_SUBNORMAL_EN
  // Only frac[0] is shifted out, so frac[0]=1 is always an exact tie: round up
  // when the kept LSB is odd. Adding into the {exp,frac} field lets a carry out
  // of an all-ones fraction become exp 1, frac 0 on its own.
  logic [WE+WF-1:0] sub_mag;
  logic             sub_rnd;
  assign sub_mag = {{WE{1'b0}}, 1'b1, frac[WF-1:1]};
  assign sub_rnd = frac[0] & frac[1];
`endif

  always_comb begin
    ieee_float = '0;
    flags      = '0;
    case (exn)
      EXN_ZERO: ieee_float = {sign, {(WE+WF){1'b0}}};
      EXN_INF: begin
        ieee_float      = {sign, {WE{1'b1}}, {WF{1'b0}}};
        flags[FLAG_INF] = 1'b1;
      end
      EXN_NAN: begin
        ieee_float      = QNAN;
        flags[FLAG_NAN] = 1'b1;
      end
      EXN_NORM: begin
        if (exp == '1) begin
          ieee_float      = {sign, {WE{1'b1}}, {WF{1'b0}}};
          flags[FLAG_OVF] = 1'b1;
        end else if (exp == '0) begin
          flags[FLAG_UNF] = 1'b1;
`ifdef FP_CONV_SUBNORMAL_EN
          ieee_float = {sign, sub_mag + (WE+WF)'(sub_rnd)};
`else
          ieee_float = {sign, {(WE+WF){1'b0}}};
`endif
        end else begin
          ieee_float = {sign, exp, frac};
        end
      end
      default: ieee_float = '0;
    endcase
  end

endmodule

// File: rtl/fp_conv_pipe.sv
// fp_conv_pipe: LAT-stage valid/stall pipe converting FloPoCo floats to IEEE.
//   clk, rst      : clock; asynchronous active-high reset
//   bus (slave)   : push_in/flopoco_float/tag_in/ready_out in,
//                   push_out/ieee_float/tag_out/stall_in out,
//                   clr_flags/flags_out sticky flags {nan, inf, ovf, unf}
// Stage 0 registers the fp_conv_core result; stages 1..LAT-1 only delay.
// The whole pipe advances unless the last stage is valid and stalled.
// Optional feature macro FP_CONV_SUBNORMAL_EN (see fp_conv_core).
module fp_conv_pipe
  import fp_conv_pkg::*;
#(
  parameter int unsigned WE    = 11,
  parameter int unsigned WF    = 52,
  parameter int unsigned LAT   = 2,
  parameter int unsigned TAG_W = 8
) (
  input logic          clk,
  input logic          rst,
  fp_conv_pipe_if.slave bus
);

  localparam int unsigned IW = WE + WF + 1;
  localparam int unsigned DW = IW + TAG_W + 4;

  logic [IW-1:0]             conv_ieee;
  logic [3:0]                conv_flags;
  logic                      advance;
  logic                      xfer;
  logic [LAT-1:0]            v_q;
  logic [LAT-1:0][DW-1:0]    st_q;
  logic [3:0]                out_cls;
  logic [3:0]                flags_q;

  fp_conv_core #(
    .WE (WE),
    .WF (WF)
  ) u_core (
    .flopoco_float (bus.flopoco_float),
    .ieee_float    (conv_ieee),
    .flags         (conv_flags)
  );

  assign advance       = !(bus.stall_in && v_q[LAT-1]);
  assign xfer          = v_q[LAT-1] && !bus.stall_in;
  assign bus.ready_out = advance;
  assign bus.push_out  = v_q[LAT-1];
  assign {bus.ieee_float, bus.tag_out, out_cls} = st_q[LAT-1];
  assign bus.flags_out = flags_q;

  // Bubbles shift through like words; data of an invalid stage is don't-care.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q  <= '0;
      st_q <= '0;
    end else if (advance) begin
      v_q[0]  <= bus.push_in;
      st_q[0] <= {conv_ieee, bus.tag_in, conv_flags};
      for (int unsigned i = 1; i < LAT; i++) begin
        v_q[i]  <= v_q[i-1];
        st_q[i] <= st_q[i-1];
      end
    end
  end

  // A set in the same cycle as a clear wins for its own bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      flags_q <= (bus.clr_flags ? 4'b0000 : flags_q) | (xfer ? out_cls : 4'b0000);
    end
  end

endmodule

// File: doc/fp_conv_pipe.md
FP_CONV_PIPE -- requirements
Module: fp_conv_pipe

Interface
REQ-001 SHALL have parameter WE, default 11, meaning exponent width for both the FloPoCo and IEEE formats.
REQ-002 SHALL have parameter WF, default 52, meaning fraction width for both formats.
REQ-003 SHALL have parameter LAT, default 2, legal range 1..4, meaning pipeline depth in cycles.
REQ-004 SHALL have parameter TAG_W, default 8, meaning sideband tag width.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 push_in  input  1  input word valid.
REQ-008 flopoco_float  input  WE+WF+3  FloPoCo word: {exn[1:0], sign, exp[WE-1:0], frac[WF-1:0]}.
REQ-009 tag_in  input  TAG_W  sideband value carried with the word.
REQ-010 ready_out  output  1  input is accepted this cycle.
REQ-011 push_out  output  1  output word valid.
REQ-012 stall_in  input  1  downstream cannot accept.
REQ-013 ieee_float  output  WE+WF+1  IEEE word {sign, exp, frac}.
REQ-014 tag_out  output  TAG_W  tag aligned with ieee_float.
REQ-015 clr_flags  input  1  clears the sticky flags.
REQ-016 flags_out  output  4  sticky flags {nan, inf, ovf, unf}.

Function
REQ-017 Exception field 00 SHALL map to signed zero, with exp and frac all zero.
REQ-018 Exception field 10 SHALL map to signed infinity, with exp all ones and frac zero.
REQ-019 Exception field 11 SHALL map to a quiet NaN: sign 0, exp all ones, frac MSB 1, other frac bits 0.
REQ-020 Exception field 01 with 0<exp<all-ones SHALL pass sign, exp and frac unchanged.
REQ-021 Exception field 01 with exp all ones SHALL map to signed infinity and mark ovf.
REQ-022 Exception field 01 with exp==0 SHALL follow REQ-034/035 and mark unf.
REQ-023 A word SHALL be accepted when push_in && ready_out.
REQ-024 ready_out SHALL equal !(stall_in && v[LAT-1]), where v[] are the per-stage valid bits; ready_out is combinational in stall_in.
REQ-025 push_out SHALL equal v[LAT-1]; the output transfers when push_out && !stall_in.
REQ-026 While stall_in && push_out, all stages SHALL hold, and ieee_float and tag_out SHALL stay stable.
REQ-027 With no stall, latency from acceptance to push_out SHALL be exactly LAT cycles, at a throughput of 1 word per cycle.
REQ-028 When push_in is low while the pipe advances, a bubble SHALL enter; there is no bubble collapsing.
REQ-029 Each flag SHALL be set on the output transfer of a word with the matching class; flags are sticky until clr_flags.
REQ-030 If clr_flags and a set occur in the same cycle, set SHALL win for that bit and other bits SHALL clear.

Reset
REQ-031 rst SHALL asynchronously clear all valid bits, push_out, flags_out, ieee_float and tag_out to 0.
REQ-032 rst mid-stream SHALL discard in-flight words, with no output transfer for them.
REQ-033 The first acceptance SHALL be possible in the first cycle after rst deasserts.

Configuration
REQ-034 With macro FP_CONV_SUBNORMAL_EN defined, exp==0 normals SHALL produce an IEEE subnormal: exp 0, frac {1, frac[WF-1:1]}, rounded to nearest-even on frac[0]; a rounding carry SHALL yield exp 1 with frac 0.
REQ-035 With FP_CONV_SUBNORMAL_EN undefined, exp==0 normals SHALL flush to signed zero.
REQ-036 The unf flag SHALL be set in both configurations.

Structure
REQ-037 Package fp_conv_pkg SHALL hold the exception encodings (EXN_ZERO, EXN_NORM, EXN_INF, EXN_NAN), the flag bit indices and the quiet-NaN constant function.
REQ-038 Sub-module fp_conv_core SHALL hold the combinational conversion and flag classification, registered in stage 0.
REQ-039 Stages 1..LAT-1 of the pipe SHALL be delay only.

Verification
REQ-040 Reset then accept FloPoCo 1.0 (exn 01, exp 0x3FF, frac 0) with LAT=2 -> push_out 2 cycles later with 0x3FF0000000000000; flags 0.
REQ-041 Accept exn 11 then exn 10 with sign 1 -> outputs 0x7FF8000000000000 then 0xFFF0000000000000; flags nan and inf set.
REQ-042 Accept exn 01, exp 0x7FF -> output 0x7FF0000000000000; ovf set; clr_flags pulse -> flags 0000.
REQ-043 Accept exn 01, exp 0, frac all ones -> with FP_CONV_SUBNORMAL_EN defined, output 0x0010000000000000; without it, output 0x0; unf set in both.
REQ-044 Stream 8 words with tags 0..7 while stall_in is held high for 3 cycles mid-stream -> all 8 emerged in order, no duplicates, outputs held stable during the stall.
REQ-045 Assert rst with 2 words in flight -> push_out 0 immediately, those words are never emitted, and the next word has exact LAT latency.
